// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: holds dispatched instructions, snoops writeback tags, issues oldest ready entry.
// Optional feature macro: RS_WAKEUP_BYPASS_EN (same-cycle writeback matches count as ready for select).

package core_pkg;
    localparam int NUM_PREGS   = 64;
    localparam int ROB_ENTRIES = 16;
    localparam int RS_ENTRIES  = 4;
    localparam int NUM_AREGS   = 32;
    localparam int XLEN        = 32;
    localparam int PREG_W      = $clog2(NUM_PREGS);
    localparam int ROB_W       = $clog2(ROB_ENTRIES);
    localparam int AREG_W      = $clog2(NUM_AREGS);

    typedef enum logic [3:0] {
        INVALID = 4'd0,
        ADD     = 4'd1,
        SUB     = 4'd2,
        AND_OP  = 4'd3,
        OR_OP   = 4'd4,
        XOR_OP  = 4'd5,
        SLL_OP  = 4'd6,
        SRL_OP  = 4'd7,
        LOAD    = 4'd8,
        STORE   = 4'd9,
        BRANCH  = 4'd10
    } opcode_t;

    typedef struct packed {
        logic              instr_valid;
        opcode_t           opcode;
        logic [AREG_W-1:0] dst_areg;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [XLEN-1:0]   imm_val;
        logic [XLEN-1:0]   pc;
        logic              br_taken;
    } disp_packet_t;

    typedef struct packed {
        logic              instr_valid;
        opcode_t           opcode;
        logic [AREG_W-1:0] dst_areg;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [XLEN-1:0]   src1_val;
        logic [XLEN-1:0]   src2_val;
        logic [XLEN-1:0]   imm_val;
        logic [XLEN-1:0]   pc;
        logic              br_taken;
        logic [ROB_W-1:0]  rob_entry_idx;
        logic              alu_en;
    } exec_packet_t;
endpackage

module rs_issue_queue #(
    parameter int RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int WB_PORTS   = 2,
    parameter int PREG_W     = core_pkg::PREG_W,
    parameter int ROB_W      = core_pkg::ROB_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  core_pkg::disp_packet_t           disp_pkt,
    input  logic [ROB_W-1:0]                 disp_rob_idx,
    input  logic                             disp_src1_rdy,
    input  logic                             disp_src2_rdy,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]       wb_preg,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output core_pkg::exec_packet_t           issue_pkt,
    output logic [$clog2(RS_ENTRIES+1)-1:0]  rs_count
);
    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
    localparam int CNT_W = $clog2(RS_ENTRIES + 1);

    core_pkg::disp_packet_t  pkt_reg   [RS_ENTRIES];
    logic [ROB_W-1:0]        rob_reg   [RS_ENTRIES];
    logic                    valid_reg [RS_ENTRIES];
    logic                    s1_reg    [RS_ENTRIES];
    logic                    s2_reg    [RS_ENTRIES];
    // older_reg[i][j] set means entry i was allocated before entry j
    logic [RS_ENTRIES-1:0]   older_reg [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]   col_older [RS_ENTRIES];

    logic [RS_ENTRIES-1:0]   valid_vec;
    logic [RS_ENTRIES-1:0]   hit1;
    logic [RS_ENTRIES-1:0]   hit2;
    logic [RS_ENTRIES-1:0]   rdy;
    logic [RS_ENTRIES-1:0]   sel_oh;
    logic [RS_ENTRIES-1:0]   alloc_oh;
    logic [RS_ENTRIES-1:0]   deq_oh;

    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        free_idx;
    logic [CNT_W-1:0]        count_next;
    logic                    alloc;
    logic                    disp_hit1;
    logic                    disp_hit2;

    function automatic logic wb_match(
        input logic [WB_PORTS-1:0]        v,
        input logic [WB_PORTS*PREG_W-1:0] tags,
        input logic [PREG_W-1:0]          tag
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign disp_hit1 = wb_match(wb_valid, wb_preg, disp_pkt.src1_preg);
    assign disp_hit2 = wb_match(wb_valid, wb_preg, disp_pkt.src2_preg);

    always_comb begin
        count_next = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            count_next = count_next + CNT_W'(valid_vec[i]);
        end
    end

    assign rs_count   = count_next;
    assign disp_ready = (count_next < CNT_W'(RS_ENTRIES));

    // Descending scan so the lowest-indexed free slot wins
    always_comb begin
        free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign alloc = disp_valid && disp_ready && !flush &&
                   disp_pkt.instr_valid && (disp_pkt.opcode != core_pkg::INVALID);

    generate
        for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
            assign valid_vec[gi] = valid_reg[gi];
            assign hit1[gi]      = wb_match(wb_valid, wb_preg, pkt_reg[gi].src1_preg);
            assign hit2[gi]      = wb_match(wb_valid, wb_preg, pkt_reg[gi].src2_preg);

`ifdef RS_WAKEUP_BYPASS_EN
            assign rdy[gi] = valid_reg[gi] && (s1_reg[gi] || hit1[gi]) && (s2_reg[gi] || hit2[gi]);
`else
            assign rdy[gi] = valid_reg[gi] && s1_reg[gi] && s2_reg[gi];
`endif

            for (genvar gj = 0; gj < RS_ENTRIES; gj++) begin : g_col
                assign col_older[gi][gj] = older_reg[gj][gi];
            end

            // Selected when ready and no ready entry is older
            assign sel_oh[gi]   = rdy[gi] && ((rdy & col_older[gi]) == '0);
            assign alloc_oh[gi] = alloc && (free_idx == IDX_W'(gi));
            assign deq_oh[gi]   = issue_valid && issue_ready && sel_oh[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    pkt_reg[gi]   <= '0;
                    rob_reg[gi]   <= '0;
                    s1_reg[gi]    <= 1'b0;
                    s2_reg[gi]    <= 1'b0;
                    older_reg[gi] <= '0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (alloc_oh[gi]) begin
                    valid_reg[gi] <= 1'b1;
                    pkt_reg[gi]   <= disp_pkt;
                    rob_reg[gi]   <= disp_rob_idx;
                    s1_reg[gi]    <= disp_src1_rdy || disp_hit1;
                    s2_reg[gi]    <= disp_src2_rdy || disp_hit2;
                    older_reg[gi] <= '0;
                end else begin
                    if (deq_oh[gi]) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (hit1[gi]) begin
                        s1_reg[gi] <= 1'b1;
                    end
                    if (hit2[gi]) begin
                        s2_reg[gi] <= 1'b1;
                    end
                    // A newly allocated entry is younger than this one
                    older_reg[gi] <= older_reg[gi] | alloc_oh;
                end
            end
        end
    endgenerate

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign issue_valid = (rdy != '0) && !flush;

    always_comb begin
        issue_pkt = '0;
        if (issue_valid) begin
            issue_pkt.instr_valid   = pkt_reg[sel_idx].instr_valid;
            issue_pkt.opcode        = pkt_reg[sel_idx].opcode;
            issue_pkt.dst_areg      = pkt_reg[sel_idx].dst_areg;
            issue_pkt.dst_preg      = pkt_reg[sel_idx].dst_preg;
            issue_pkt.src1_preg     = pkt_reg[sel_idx].src1_preg;
            issue_pkt.src2_preg     = pkt_reg[sel_idx].src2_preg;
            issue_pkt.src1_val      = '0;
            issue_pkt.src2_val      = '0;
            issue_pkt.imm_val       = pkt_reg[sel_idx].imm_val;
            issue_pkt.pc            = pkt_reg[sel_idx].pc;
            issue_pkt.br_taken      = pkt_reg[sel_idx].br_taken;
            issue_pkt.rob_entry_idx = rob_reg[sel_idx];
            issue_pkt.alu_en        = 1'b1;
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Scoreboard bench for rs_issue_queue: expected issue packets queued at dispatch, compared as they issue.
module tb_rs_issue_queue;
    import core_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               disp_valid;
    logic               disp_ready;
    disp_packet_t       disp_pkt;
    logic [3:0]         disp_rob_idx;
    logic               disp_src1_rdy;
    logic               disp_src2_rdy;
    logic [1:0]         wb_valid;
    logic [11:0]        wb_preg;
    logic               issue_valid;
    logic               issue_ready;
    exec_packet_t       issue_pkt;
    logic [2:0]         rs_count;

    int n_checks = 0;
    int n_fail   = 0;
    exec_packet_t sb[$];

    rs_issue_queue #(.RS_ENTRIES(4), .WB_PORTS(2), .PREG_W(6), .ROB_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
        .disp_rob_idx(disp_rob_idx), .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pkt(issue_pkt),
        .rs_count(rs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic disp_packet_t mk(input opcode_t op, input int dst, input int s1, input int s2, input int imm);
        disp_packet_t d;
        d = '0;
        d.instr_valid = 1'b1;
        d.opcode      = op;
        d.dst_areg    = 5'(dst + 1);
        d.dst_preg    = 6'(dst);
        d.src1_preg   = 6'(s1);
        d.src2_preg   = 6'(s2);
        d.imm_val     = 32'(imm);
        d.pc          = 32'h0000_1000 + 32'(imm * 4);
        d.br_taken    = imm[0];
        return d;
    endfunction

    function automatic exec_packet_t to_exec(input disp_packet_t d, input logic [3:0] rob);
        exec_packet_t e;
        e = '0;
        e.instr_valid   = 1'b1;
        e.opcode        = d.opcode;
        e.dst_areg      = d.dst_areg;
        e.dst_preg      = d.dst_preg;
        e.src1_preg     = d.src1_preg;
        e.src2_preg     = d.src2_preg;
        e.imm_val       = d.imm_val;
        e.pc            = d.pc;
        e.br_taken      = d.br_taken;
        e.rob_entry_idx = rob;
        e.alu_en        = 1'b1;
        return e;
    endfunction

    // One clock: scoreboard check of any issue on the negedge, then return 1ns after the posedge
    task automatic tick();
        exec_packet_t exp;
        @(negedge clk);
        if (issue_valid && issue_ready) begin
            n_checks++;
            $display("issue rob=%0d op=%0d dst_preg=%0d", issue_pkt.rob_entry_idx, issue_pkt.opcode, issue_pkt.dst_preg);
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got rob=%0d, scoreboard empty", issue_pkt.rob_entry_idx);
            end else begin
                exp = sb.pop_front();
                if (issue_pkt !== exp) begin
                    n_fail++;
                    $display("FAIL issue_pkt: got %h want %h", issue_pkt, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int bound, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; disp_pkt = '0; disp_rob_idx = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; wb_valid = '0; wb_preg = '0;
    endtask

    task automatic drive_disp(input disp_packet_t d, input int rob, input logic r1, input logic r2);
        disp_valid = 1'b1; disp_pkt = d; disp_rob_idx = 4'(rob);
        disp_src1_rdy = r1; disp_src2_rdy = r2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; issue_ready = 1'b0; idle();
        #12;
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rs_count); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
        n_checks++; if (issue_pkt !== '0) begin n_fail++; $display("FAIL reset_issue_pkt: got %h want 0", issue_pkt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_issue();
        disp_packet_t d;
        d = mk(ADD, 5, 1, 2, 17);
        issue_ready = 1'b1;
        drive_disp(d, 3, 1'b1, 1'b1);
        sb.push_back(to_exec(d, 4'd3));
        tick();
        idle();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_issue_valid: got %b want 1", issue_valid); end
        n_checks++; if (issue_pkt.opcode !== ADD || issue_pkt.dst_preg !== 6'd5 || issue_pkt.rob_entry_idx !== 4'd3) begin
            n_fail++; $display("FAIL basic_fields: got op=%0d dst=%0d rob=%0d want op=1 dst=5 rob=3",
                issue_pkt.opcode, issue_pkt.dst_preg, issue_pkt.rob_entry_idx);
        end
        wait_empty(4, "basic");
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL basic_count: got %0d want 0", rs_count); end
    endtask

    task automatic test_wakeup_all();
        disp_packet_t d;
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = mk(SUB, 20 + i, 10, 3, 40 + i);
            drive_disp(d, i, 1'b0, 1'b1);
            sb.push_back(to_exec(d, 4'(i)));
            tick();
        end
        idle();
        n_checks++; if (rs_count !== 3'd4) begin n_fail++; $display("FAIL wake_full_count: got %0d want 4", rs_count); end
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL wake_disp_ready: got %b want 0", disp_ready); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wait_valid: got %b want 0", issue_valid); end
        issue_ready = 1'b1;
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd10};
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_same_cycle: got %b want 1", issue_valid); end
`else
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %b want 0", issue_valid); end
`endif
        tick();
        idle();
        wait_empty(8, "wake");
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL wake_drain_count: got %0d want 0", rs_count); end
    endtask

    task automatic test_age_order();
        disp_packet_t a, b;
        a = mk(OR_OP, 30, 7, 4, 5);
        b = mk(XOR_OP, 31, 4, 4, 6);
        issue_ready = 1'b0;
        drive_disp(a, 5, 1'b0, 1'b1); tick();
        drive_disp(b, 6, 1'b1, 1'b1); tick();
        idle();
        sb.push_back(to_exec(b, 4'd6));
        sb.push_back(to_exec(a, 4'd5));
        issue_ready = 1'b1;
        n_checks++; if (issue_pkt.rob_entry_idx !== 4'd6) begin n_fail++; $display("FAIL age_young_first: got rob=%0d want 6", issue_pkt.rob_entry_idx); end
        tick();
        n_checks++; if (issue_valid !== 1'b0 || rs_count !== 3'd1) begin
            n_fail++; $display("FAIL age_a_waits: got valid=%b count=%0d want valid=0 count=1", issue_valid, rs_count);
        end
        wb_valid = 2'b10; wb_preg = {6'd7, 6'd0};
        tick();
        idle();
        wait_empty(4, "age");
    endtask

    task automatic test_disp_wakeup();
        disp_packet_t d;
        d = mk(LOAD, 12, 4, 9, 9);
        issue_ready = 1'b1;
        drive_disp(d, 7, 1'b1, 1'b0);
        wb_valid = 2'b10; wb_preg = {6'd9, 6'd0};
        sb.push_back(to_exec(d, 4'd7));
        tick();
        idle();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL disp_wake_valid: got %b want 1", issue_valid); end
        wait_empty(4, "disp_wake");
    endtask

    task automatic test_back_to_back();
        disp_packet_t d;
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = mk(ADD, 40 + i, 1, 2, 80 + i);
            drive_disp(d, 8 + i, 1'b1, 1'b1);
            sb.push_back(to_exec(d, 4'(8 + i)));
            tick();
        end
        d = mk(SLL_OP, 50, 1, 2, 90);
        drive_disp(d, 12, 1'b1, 1'b1);
        issue_ready = 1'b1;
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_disp_ready: got %b want 0", disp_ready); end
        tick();
        n_checks++; if (rs_count !== 3'd3) begin n_fail++; $display("FAIL full_no_alloc: got %0d want 3", rs_count); end
        issue_ready = 1'b0;
        sb.push_back(to_exec(d, 4'd12));
        tick();
        n_checks++; if (rs_count !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", rs_count); end
        disp_valid = 1'b0; issue_ready = 1'b1;
        tick();
        d = mk(SRL_OP, 51, 1, 2, 91);
        drive_disp(d, 13, 1'b1, 1'b1);
        sb.push_back(to_exec(d, 4'd13));
        tick();
        idle();
        n_checks++; if (rs_count !== 3'd3) begin n_fail++; $display("FAIL simul_disp_issue: got %0d want 3", rs_count); end
        wait_empty(8, "b2b");
    endtask

    task automatic test_flush();
        disp_packet_t d;
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(mk(ADD, 2 + i, 1, 1, i), i, 1'b1, 1'b1);
            tick();
        end
        n_checks++; if (rs_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", rs_count); end
        drive_disp(mk(BRANCH, 9, 1, 1, 3), 14, 1'b1, 1'b1);
        flush = 1'b1; issue_ready = 1'b1;
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_issue_valid: got %b want 0", issue_valid); end
        tick();
        idle();
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", rs_count); end
        tick(); tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", issue_valid); end
        d = mk(ADD, 3, 1, 1, 0);
        d.instr_valid = 1'b0;
        drive_disp(d, 1, 1'b1, 1'b1); tick();
        d = mk(INVALID, 3, 1, 1, 0);
        drive_disp(d, 2, 1'b1, 1'b1); tick();
        idle();
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL ignored_disp: got %0d want 0", rs_count); end
    endtask

    task automatic test_async_reset();
        issue_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_disp(mk(SUB, 6 + i, 1, 1, i), i, 1'b1, 1'b1);
            tick();
        end
        idle();
        n_checks++; if (rs_count !== 3'd2) begin n_fail++; $display("FAIL async_pre_count: got %0d want 2", rs_count); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rs_count !== 3'd0 || disp_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_count_ready: got count=%0d ready=%b want 0/1", rs_count, disp_ready);
        end
        n_checks++; if (issue_valid !== 1'b0 || issue_pkt !== '0) begin
            n_fail++; $display("FAIL async_issue: got valid=%b pkt=%h want 0/0", issue_valid, issue_pkt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if (rs_count !== 3'd0) begin n_fail++; $display("FAIL async_post_count: got %0d want 0", rs_count); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup_all();
        test_age_order();
        test_disp_wakeup();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
